// File: rtl/seq_intersect_driver.sv
// Intersect-trial stimulus driver and verdict checker for the sequence-operation checkers.
// Optional macro SEQ_DRV_STICKY_ERR_EN adds a sticky_err output latched on any failing trial.
module seq_intersect_driver #(
    parameter int WIN       = 5,
    parameter int MATCH_LAT = 2,
    parameter int FAIL_LAT  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [WIN-1:0] pattern_1,
    input  logic [WIN-1:0] pattern_2,
    input  logic           match,
    input  logic           fail,
    output logic           en,
    output logic           signal_1,
    output logic           signal_2,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [3:0]     err_cnt
`ifdef SEQ_DRV_STICKY_ERR_EN
    ,
    output logic           sticky_err
`endif
);

    localparam int DRAIN_LEN = (MATCH_LAT > FAIL_LAT) ? MATCH_LAT : FAIL_LAT;
    localparam int LAST      = WIN + DRAIN_LEN;
    localparam int CW        = $clog2(LAST + 1) + 1;

    typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, REPORT} state_t;

    state_t         state;
    logic [CW-1:0]  c;
    logic [CW-1:0]  obs;
    logic [WIN-1:0] pat_1;
    logic [WIN-1:0] pat_2;
    logic [WIN-1:0] exp_and;
    logic           exp_match;
    logic           exp_fail;
    logic           drv_1;
    logic           drv_2;
    logic [3:0]     err_next;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic m1, input logic m2);
        logic [4:0] s;
        s = {1'b0, a} + {4'b0, m1} + {4'b0, m2};
        return (s > 5'd15) ? 4'd15 : s[3:0];
    endfunction

    // c leads the driven cycle by one: during window cycle t the counter holds t+1,
    // so the output registered at an edge uses index c and the sample taken there is cycle c-1.
    assign obs = c - CW'(1);

    always_comb begin
        exp_match = 1'b0;
        drv_1     = 1'b0;
        drv_2     = 1'b0;
        for (int j = 0; j < WIN; j++) begin
            if (exp_and[j] && (obs == CW'(j + MATCH_LAT)))
                exp_match = 1'b1;
            if (c == CW'(j)) begin
                drv_1 = pat_1[j];
                drv_2 = pat_2[j];
            end
        end
        exp_fail = (obs == CW'(FAIL_LAT)) && (exp_and == '0);
        err_next = sat_add(err_cnt, match != exp_match, fail != exp_fail);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            c          <= '0;
            en         <= 1'b0;
            signal_1   <= 1'b0;
            signal_2   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= 4'd0;
`ifdef SEQ_DRV_STICKY_ERR_EN
            sticky_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_1   <= pattern_1;
                        pat_2   <= pattern_2;
                        exp_and <= pattern_1 & pattern_2;
                        err_cnt <= 4'd0;
                        c       <= '0;
                        busy    <= 1'b1;
                        pass    <= 1'b0;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    en       <= (c == '0);
                    signal_1 <= drv_1;
                    signal_2 <= drv_2;
                    if (c != '0)
                        err_cnt <= err_next;
                    c <= c + CW'(1);
                    if (c == CW'(WIN))
                        state <= DRAIN;
                end
                DRAIN: begin
                    en       <= 1'b0;
                    signal_1 <= 1'b0;
                    signal_2 <= 1'b0;
                    err_cnt  <= err_next;
                    c        <= c + CW'(1);
                    if (c == CW'(LAST)) begin
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                        state <= REPORT;
`ifdef SEQ_DRV_STICKY_ERR_EN
                        if (err_next != 4'd0)
                            sticky_err <= 1'b1;
`endif
                    end
                end
                REPORT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_intersect_driver.sv
// Directed bench for seq_intersect_driver with a behavioural intersect checker and fault modes.
module tb_seq_intersect_driver;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [4:0] pattern_1 = '0;
    logic [4:0] pattern_2 = '0;
    logic       match = 1'b0;
    logic       fail = 1'b0;
    logic       en, signal_1, signal_2, busy, done, pass;
    logic [3:0] err_cnt;
`ifdef SEQ_DRV_STICKY_ERR_EN
    logic       sticky_err;
`endif

    int errs = 0;
    int checks = 0;
    int mode = 0;

    seq_intersect_driver dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .pattern_1(pattern_1), .pattern_2(pattern_2),
        .match(match), .fail(fail),
        .en(en), .signal_1(signal_1), .signal_2(signal_2),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
`ifdef SEQ_DRV_STICKY_ERR_EN
        , .sticky_err(sticky_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Conforming checker: match MATCH_LAT=2 cycles after an overlap in the window,
    // fail in cycle 5 when no overlap occurred. Modes 1..3 inject faults.
    int cnt = 100;
    bit hist [5];
    always @(posedge clk) begin
        logic m, f, any;
        #1;
        if (en === 1'b1) begin
            cnt = 0;
            for (int i = 0; i < 5; i++) hist[i] = 1'b0;
        end else if (cnt < 100) begin
            cnt++;
        end
        if (cnt < 5) hist[cnt] = signal_1 & signal_2;
        m = (cnt >= 2 && cnt < 7) ? hist[cnt-2] : 1'b0;
        any = 1'b0;
        for (int i = 0; i < 5; i++) any |= hist[i];
        f = (cnt == 5) && !any;
        case (mode)
            1: begin match = m;    fail = 1'b0; end
            2: begin match = 1'b1; fail = f;    end
            3: begin match = 1'b1; fail = 1'b1; end
            default: begin match = m; fail = f; end
        endcase
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic run_trial(input string tag, input logic [4:0] p1, input logic [4:0] p2,
                             input int md, input int exp_pass, input int exp_err,
                             input int busy_start_n);
        int n;
        int en_first;
        int en_extra;
        logic [4:0] s1v, s2v;
        mode = md;
        @(negedge clk);
        pattern_1 = p1;
        pattern_2 = p2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        n = 0; en_first = 0; en_extra = 0; s1v = '0; s2v = '0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
            if (n == 1) en_first = en;
            else if (en === 1'b1) en_extra++;
            if (n >= 1 && n <= 5) begin
                s1v[n-1] = signal_1;
                s2v[n-1] = signal_2;
            end
            start = (n == busy_start_n);
        end
        start = 1'b0;
        chk({tag, "_done_cycle"}, n, 11);
        chk({tag, "_en_cycle0"}, en_first, 1);
        chk({tag, "_en_extra"}, en_extra, 0);
        chk({tag, "_sig1"}, s1v, p1);
        chk({tag, "_sig2"}, s2v, p2);
        chk({tag, "_pass"}, pass, exp_pass);
        chk({tag, "_err_cnt"}, err_cnt, exp_err);
    endtask

    task automatic count_dones(input string tag, input int cycles, input int exp);
        int d = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done === 1'b1) d++;
        end
        chk(tag, d, exp);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en", en, 0);
        chk("rst_sig", {signal_1, signal_2}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_cnt, 0);
`ifdef SEQ_DRV_STICKY_ERR_EN
        chk("rst_sticky", sticky_err, 0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        run_trial("zero", 5'b00000, 5'b00000, 0, 1, 0, -1);
        @(negedge clk);
        chk("post_done", done, 0);
        chk("post_busy", busy, 0);
        chk("post_pass_hold", pass, 1);

        run_trial("overlap", 5'b00100, 5'b00110, 0, 1, 0, -1);
`ifdef SEQ_DRV_STICKY_ERR_EN
        chk("sticky_clean", sticky_err, 0);
`endif
        run_trial("fail_tied0", 5'b00000, 5'b00000, 1, 0, 1, -1);
`ifdef SEQ_DRV_STICKY_ERR_EN
        chk("sticky_set", sticky_err, 1);
`endif
        run_trial("match_tied1", 5'b00100, 5'b00110, 2, 0, 9, -1);
        run_trial("multi", 5'b10111, 5'b11101, 0, 1, 0, -1);
`ifdef SEQ_DRV_STICKY_ERR_EN
        chk("sticky_hold", sticky_err, 1);
`endif
        run_trial("disjoint", 5'b11111, 5'b00000, 0, 1, 0, -1);
        run_trial("zero_match1", 5'b00000, 5'b00000, 2, 0, 10, -1);
        run_trial("saturate", 5'b00000, 5'b00000, 3, 0, 15, -1);

        run_trial("busy_start", 5'b00100, 5'b00110, 0, 1, 0, 4);
        count_dones("busy_start_one_done", 16, 0);
        chk("busy_start_idle", busy, 0);

        run_trial("b2b_a", 5'b01000, 5'b01000, 0, 1, 0, -1);
        run_trial("b2b_b", 5'b00001, 5'b00011, 0, 1, 0, -1);

        // Abort a trial in cycle 6 with reset.
        mode = 0;
        @(negedge clk);
        pattern_1 = 5'b00000;
        pattern_2 = 5'b00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_outs", {en, signal_1, signal_2, busy, done, pass}, 0);
        chk("midrst_err", err_cnt, 0);
`ifdef SEQ_DRV_STICKY_ERR_EN
        chk("midrst_sticky", sticky_err, 0);
`endif
        rst_n = 1'b1;
        count_dones("midrst_no_done", 15, 0);
        run_trial("after_rst", 5'b00100, 5'b00110, 0, 1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/seq_intersect_driver.md
# seq_intersect_driver

Stimulus-and-verdict driver for the sequence-operation checkers. It launches one intersect trial: it pulses `en`, then plays two programmed bit patterns onto `signal_1`/`signal_2` across the evaluation window. It then watches the checker's `match`/`fail` outputs and compares them cycle by cycle against the expected response. It sits on the checker side of the same handshake and is used both in self-checking benches and as an on-chip built-in self-test (BIST) sequencer in front of the checker blocks.

## Interface
- `WIN`, 5: evaluation window length in cycles; the `en` cycle counts as cycle 0.
- `MATCH_LAT`, 2: cycles from a driven cycle with `signal_1 & signal_2 = 1` to the expected `match` pulse.
- `FAIL_LAT`, 5: cycles from cycle 0 to the expected single-cycle `fail` pulse.
- `clk` in 1: the single clock; all logic is on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: launches a trial; sampled only in IDLE.
- `pattern_1` in `WIN`: bit k is driven on `signal_1` in window cycle k.
- `pattern_2` in `WIN`: bit k is driven on `signal_2` in window cycle k.
- `match` in 1: the checker's match output.
- `fail` in 1: the checker's fail output.
- `en` out 1: trigger to the checker.
- `signal_1` out 1: stimulus to the checker.
- `signal_2` out 1: stimulus to the checker.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse when the verdict is valid.
- `pass` out 1: verdict; valid while `done` is high and held until the next accepted `start`.
- `err_cnt` out 4: mismatch count for the last trial, saturating at 15.

## Operation
- **States:** IDLE, DRIVE, DRAIN, REPORT.
- **IDLE:**
  - When `start` is 1, latch `pattern_1`/`pattern_2` and compute `exp_and = pattern_1 & pattern_2`.
  - Clear the trial `err_cnt`, clear the cycle counter `k`, then go to DRIVE.
  - `start` is ignored in every other state.
- **DRIVE:** lasts `WIN` cycles, k = 0..WIN-1.
  - All driven outputs are registered.
  - `en` = 1 only at k = 0.
  - `signal_1` = `pattern_1[k]`, `signal_2` = `pattern_2[k]`.
- **DRAIN:** lasts `max(MATCH_LAT, FAIL_LAT)` cycles.
  - `en`, `signal_1` and `signal_2` are 0.
  - Monitoring continues.
- **Monitoring** (DRIVE and DRAIN, observation cycle t = k counted from cycle 0):
  - **Expected `match`** at t = j + MATCH_LAT, for every j < WIN with `exp_and[j]` = 1. For any other t, `match` must be 0.
  - **Expected `fail`** = 1 at t = FAIL_LAT if and only if `exp_and` = 0; otherwise `fail` = 0 at every t.
  - Each cycle where `match` differs from its expectation adds 1 to `err_cnt`.
  - Each cycle where `fail` differs from its expectation also adds 1. Both mismatches in the same cycle add 2.
  - `err_cnt` saturates at 15.
- **REPORT:** one cycle.
  - `done` = 1, `pass` = (`err_cnt` == 0).
  - Then go to IDLE.
- **Reset:** `rst_n` low at any edge returns to IDLE, aborts any trial in progress, and does not produce `done`.

## Timing
- **Reset values:** `en`, `signal_1`, `signal_2`, `busy`, `done`, `pass` = 0; `err_cnt` = 0.
- `start` sampled high at edge N gives `en` = 1 in the cycle after edge N+1, which is cycle 0. The one cycle of latency comes from latching the patterns.
- `busy` rises after edge N.
- With defaults, DRIVE covers cycles 0–4 and DRAIN covers cycles 5–9. `done` is high in cycle 10.
- Trial length is 1 + WIN + max(MATCH_LAT, FAIL_LAT) + 1 cycles, which is 12 with defaults.
- `start` held high continuously launches back-to-back trials, one every trial length plus one IDLE cycle.
- `match`/`fail` are sampled in the same edge that advances `k`. Values seen after REPORT are ignored.

## Configuration
- **`SEQ_DRV_STICKY_ERR_EN`:**
  - **Defined:** adds output `sticky_err` (1 bit). It is set when any trial ends with `pass` = 0 and cleared only by `rst_n`. `err_cnt` still resets per trial.
  - **Undefined:** the port and its logic are absent; each trial is fully independent.

## Test plan
- **All-zero patterns:** `pattern_1` = `pattern_2` = 5'b00000, with a conforming checker → `fail` pulse in cycle 5, no `match`. Required: `done` in cycle 10, `pass` = 1, `err_cnt` = 0.
- **Single overlap:** `pattern_1` = 5'b00100, `pattern_2` = 5'b00110 → `match` expected only in cycle 4, `fail` held 0. Required: `pass` = 1.
- **Fault injection:** `fail` tied to 0 with all-zero patterns → `err_cnt` = 1, `pass` = 0. Separately, `match` tied to 1 with the patterns from the single-overlap case → `err_cnt` = 9, `pass` = 0.
- **Start while busy:** a second `start` pulse in cycle 3 → ignored, exactly one `done`. A `start` in the cycle after `done` → a new trial with cycle 0 two cycles later.
- **Reset mid-trial:** `rst_n` low at cycle 6 → all outputs 0 on the next cycle, no `done`. A following trial runs normally.
- **`SEQ_DRV_STICKY_ERR_EN` defined:** a failing trial followed by a passing trial → `sticky_err` stays 1 until `rst_n` is asserted.
